vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator for the Block Invaders display path. Consumes the 25 MHz pixel clock and the slow 4 Hz game-clock toggle from the clock generator.
- Produces VGA hsync/vsync, pixel coordinates, a video-enable signal and frame/line markers.
- Re-times the asynchronous 4 Hz game tick into a single-cycle game_step pulse. The pulse is issued at the start of vertical blanking, so sprite and position state only changes off-screen.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 means hsync/vsync are driven 0 when asserted

Ports:
- clk  in  1  pixel clock, 25 MHz (clk_25M)
- reset  in  1  asynchronous, active-high
- tick_in  in  1  4 Hz toggle (clk_4Hz), asynchronous to clk
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- video_on  out  1  high when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when pixel_x == 0
- frame_start  out  1  one-cycle pulse at (0,0)
- vblank_start  out  1  one-cycle pulse at (0,V_VISIBLE)
- game_step  out  1  one-cycle game update strobe

Behaviour:
- Derived totals:
  - H_TOTAL = sum of the four H parameters (800 by default).
  - V_TOTAL = sum of the four V parameters (525 by default).
  - Both totals must be ≤ 1024; this is checked by an elaboration-time assertion.
- Counters:
  - h_cnt increments every clk and wraps H_TOTAL-1 -> 0.
  - v_cnt increments only when h_cnt wraps, and itself wraps V_TOTAL-1 -> 0.
- Output stage:
  - All outputs are registered, with 1-cycle latency from the internal counters. They are decoded from the current h_cnt/v_cnt and registered together, so they are glitch-free and mutually aligned.
- Sync timing:
  - hsync is asserted while pixel_x is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]. Default: 656..751.
  - vsync is asserted while pixel_y is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], for the whole line. Default: 490..491.
- Reset state:
  - Counters = 0.
  - pixel_x = 0, pixel_y = 0, video_on = 0, all pulses = 0.
  - hsync and vsync deasserted: 1 when SYNC_ACTIVE_LOW = 1.
  - Tick synchroniser flops = 0; pending = 0.
- First clock edge after reset release: outputs show (0,0) with video_on = 1 and frame_start = 1, and the counters advance to (1,0).
- Tick path:
  - tick_in passes through 2 synchroniser flops, then a previous-value flop.
  - A rising edge (sync2 & ~prev) sets the pending flag.
- Release rule:
  - When pending = 1 and the output stage is issuing vblank_start, game_step = 1 for exactly that cycle and pending clears.
- Simultaneous events:
  - If a new edge is detected in the same cycle as a release, game_step still fires and pending stays set. A second step therefore fires at the next frame's vblank_start.
  - Multiple edges within one frame collapse into one pending step.
- Edge timing relative to vblank:
  - An edge detected during rows 480..524 fires at the next frame's vblank_start.
  - Worst-case edge-to-step latency is 1 frame plus 3 cycles.
- Reset asserted mid-frame:
  - Everything returns to the reset state immediately (asynchronous); any pending step is discarded.
  - The raster restarts at (0,0) after release.

Decomposition:
- Shared package vga_pkg holds:
  - The default H/V timing constants.
  - Localparams H_TOTAL and V_TOTAL.
  - The 10-bit coordinate width constant.
- One sub-module, tick_sync_edge: the 2-flop synchroniser plus rising-edge detector, reusable for the button inputs. Its output is a 1-cycle pulse.
- The counters, decode logic and pending flag stay in the top module.

Test Plan:
- Frame period:
  - Stimulus: release reset and run 2 frames.
  - Required: frame_start pulses are exactly 420000 cycles apart; line_start pulses are 800 cycles apart; vblank_start occurs 384000 cycles after frame_start.
- Sync widths:
  - hsync is low for exactly 96 cycles, beginning on the cycle pixel_x = 656.
  - vsync is low for exactly 1600 cycles, covering pixel_y 490..491.
  - video_on is high for 640 cycles per visible line and low on all of lines 480..524.
- Step in active video:
  - Stimulus: toggle tick_in 0->1 while pixel_y = 100.
  - Required: one game_step pulse, coincident with vblank_start of the same frame; none at the following vblank_start.
- Step in blanking:
  - Stimulus: tick_in rises while pixel_y = 500.
  - Required: no step in the current frame; game_step at (0,480) of the next frame.
- Collapse:
  - Stimulus: two tick_in rising edges within one frame (rows 50 and 300).
  - Required: exactly one game_step.
- Release collision:
  - Stimulus: an edge reaches sync2 on the release cycle.
  - Required: game_step fires, then fires again at the next vblank_start.
- Mid-frame reset:
  - Stimulus: pulse reset at (300,200) with a step pending.
  - Required: outputs go to reset values immediately; the first post-release cycle shows (0,0) with frame_start = 1; no game_step until a new tick edge.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared raster timing constants and bundle types for the VGA display path.
// Defaults describe 640x480 @ 60 Hz on a 25 MHz pixel clock.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;

    localparam int H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF
                           + H_SYNC_DEF + H_BACK_DEF;
    localparam int V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF
                           + V_SYNC_DEF + V_BACK_DEF;

    typedef struct packed {
        logic               hsync;
        logic               vsync;
        logic               video_on;
        logic               line_start;
        logic               frame_start;
        logic               vblank_start;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } raster_t;

    function automatic logic in_span(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchroniser plus rising-edge detector for slow async inputs.
// Emits a one-cycle pulse per rising edge of din.
module tick_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters, registered sync/marker decode and the game-step strobe
// that is deferred to vertical blanking.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_DEF,
    parameter int H_FRONT         = H_FRONT_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BACK          = H_BACK_DEF,
    parameter int V_VISIBLE       = V_VISIBLE_DEF,
    parameter int V_FRONT         = V_FRONT_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BACK          = V_BACK_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_in,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank_start,
    output logic               game_step
);

    localparam int HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(VT - 1);
    localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_LO  = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_HI  =
        COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_LO  = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_HI  =
        COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    if ((HT > 1024) || (VT > 1024)) begin : g_bad_totals
        $error("vga_timing_gen: H/V totals must not exceed 1024");
    end

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
            if (h_wrap) begin
                v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
            end
        end
    end

    raster_t nxt;
    raster_t out_q;

    always_comb begin
        nxt              = '0;
        nxt.x            = h_cnt;
        nxt.y            = v_cnt;
        nxt.video_on     = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        nxt.hsync        = in_span(h_cnt, HS_LO, HS_HI) ^ SYNC_ACTIVE_LOW;
        nxt.vsync        = in_span(v_cnt, VS_LO, VS_HI) ^ SYNC_ACTIVE_LOW;
        nxt.line_start   = (h_cnt == '0);
        nxt.frame_start  = (h_cnt == '0) && (v_cnt == '0);
        nxt.vblank_start = (h_cnt == '0) && (v_cnt == V_VIS);
    end

    logic rise;
    logic pending;
    logic rel;

    tick_sync_edge u_tick (
        .clk   (clk),
        .reset (reset),
        .din   (tick_in),
        .rise  (rise)
    );

    // A fresh edge on the release cycle re-arms pending for the next frame.
    assign rel = pending & nxt.vblank_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_q.hsync <= SYNC_ACTIVE_LOW;
            out_q.vsync <= SYNC_ACTIVE_LOW;
            pending     <= 1'b0;
            game_step   <= 1'b0;
        end else begin
            out_q     <= nxt;
            pending   <= rise | (pending & ~rel);
            game_step <= rel;
        end
    end

    assign hsync        = out_q.hsync;
    assign vsync        = out_q.vsync;
    assign video_on     = out_q.video_on;
    assign pixel_x      = out_q.x;
    assign pixel_y      = out_q.y;
    assign line_start   = out_q.line_start;
    assign frame_start  = out_q.frame_start;
    assign vblank_start = out_q.vblank_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (48x32 totals) so that
// many frames fit in a short run; a position/tick model checks every cycle.
module tb_vga_timing_gen;

    localparam int HV = 32;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 6;
    localparam int VV = 24;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_in = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       line_start;
    logic       frame_start;
    logic       vblank_start;
    logic       game_step;

    vga_timing_gen #(
        .H_VISIBLE       (HV),
        .H_FRONT         (HF),
        .H_SYNC          (HS),
        .H_BACK          (HB),
        .V_VISIBLE       (VV),
        .V_FRONT         (VF),
        .V_SYNC          (VS),
        .V_BACK          (VB),
        .SYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick_in      (tick_in),
        .hsync        (hsync),
        .vsync        (vsync),
        .video_on     (video_on),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .line_start   (line_start),
        .frame_start  (frame_start),
        .vblank_start (vblank_start),
        .game_step    (game_step)
    );

    always #5 clk = ~clk;

    int tot = 0;
    int bad = 0;
    int steps = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // Model: n = clock edges since reset release; outputs show raster
    // position n-1. A tick rise first sampled on edge r arms the step on
    // edge r+2; an armed step fires on the edge that shows (0,VV).
    int n = 0;
    int mx = 0;
    int my = 0;
    bit mv = 0;
    bit pend = 0;
    bit last_tk = 0;
    bit exp_step = 0;
    int rq[$];

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0; mv = 0; mx = 0; my = 0;
                pend = 0; last_tk = 0; exp_step = 0;
                rq.delete();
            end else begin
                n++;
                mv = 1;
                mx = ((n - 1) % FR) % HT;
                my = ((n - 1) % FR) / HT;
                exp_step = 0;
                if (mx == 0 && my == VV && pend) begin
                    exp_step = 1;
                    pend = 0;
                end
                while (rq.size() > 0 && rq[0] + 2 == n) begin
                    pend = 1;
                    void'(rq.pop_front());
                end
                if (tick_in && !last_tk) rq.push_back(n);
                last_tk = tick_in;
            end
        end
    end

    int cyc = 0;
    int last_fs = -1;
    int last_ls = -1;
    int hs_run = 0;
    int vs_run = 0;
    int vo_run = 0;
    logic hs_d = 1'b1;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!mv) begin
                chk("rst_hsync", hsync, 1);
                chk("rst_vsync", vsync, 1);
                chk("rst_video", video_on, 0);
                chk("rst_x", pixel_x, 0);
                chk("rst_y", pixel_y, 0);
                chk("rst_pulses",
                    {line_start, frame_start, vblank_start, game_step}, 0);
            end else begin
                chk("pixel_x", pixel_x, mx);
                chk("pixel_y", pixel_y, my);
                chk("video_on", video_on, (mx < HV) && (my < VV));
                chk("hsync", hsync,
                    !(mx >= HV + HF && mx < HV + HF + HS));
                chk("vsync", vsync,
                    !(my >= VV + VF && my < VV + VF + VS));
                chk("line_start", line_start, mx == 0);
                chk("frame_start", frame_start, mx == 0 && my == 0);
                chk("vblank_start", vblank_start, mx == 0 && my == VV);
                chk("game_step", game_step, exp_step);
            end
            if (game_step) steps++;
            if (reset) begin
                last_fs = -1; last_ls = -1;
                hs_run = 0; vs_run = 0; vo_run = 0;
                hs_d = 1'b1;
            end else begin
                if (frame_start) begin
                    if (last_fs >= 0) chk("frame_period", cyc - last_fs, 1536);
                    last_fs = cyc;
                end
                if (line_start) begin
                    if (last_ls >= 0) chk("line_period", cyc - last_ls, 48);
                    last_ls = cyc;
                end
                if (vblank_start && last_fs >= 0)
                    chk("fs_to_vblank", cyc - last_fs, 1152);
                if (!hsync && hs_d) chk("hsync_start_x", pixel_x, 36);
                hs_d = hsync;
                if (!hsync) hs_run++;
                else if (hs_run > 0) begin
                    chk("hsync_width", hs_run, 6);
                    hs_run = 0;
                end
                if (!vsync) vs_run++;
                else if (vs_run > 0) begin
                    chk("vsync_width", vs_run, 96);
                    vs_run = 0;
                end
                if (video_on) vo_run++;
                else if (vo_run > 0) begin
                    chk("video_width", vo_run, 32);
                    vo_run = 0;
                end
            end
        end
    end

    task automatic wait_pos(input int x, input int y);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mv && mx == x && my == y) && k < 2 * FR + 10);
        if (!(mv && mx == x && my == y)) chk("wait_timeout", 0, 1);
    endtask

    task automatic run_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    int base;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        run_cycles(3);
        #2 reset = 1'b0;

        // Rise during active video: steps at this frame's vblank only.
        wait_pos(0, 5);
        base = steps;
        tick_in = 1'b1;
        wait_pos(10, 8);
        tick_in = 1'b0;
        run_cycles(2 * FR);
        chk("steps_active", steps - base, 1);

        // Rise in blanking: deferred to the next frame's vblank.
        wait_pos(0, 28);
        base = steps;
        tick_in = 1'b1;
        wait_pos(0, 30);
        tick_in = 1'b0;
        wait_pos(0, 31);
        chk("steps_blank_early", steps - base, 0);
        wait_pos(5, 24);
        chk("steps_blank", steps - base, 1);
        run_cycles(FR);
        chk("steps_blank_after", steps - base, 1);

        // Two rises in one frame collapse into a single step.
        wait_pos(0, 3);
        base = steps;
        tick_in = 1'b1;
        wait_pos(0, 6);
        tick_in = 1'b0;
        wait_pos(0, 15);
        tick_in = 1'b1;
        wait_pos(0, 18);
        tick_in = 1'b0;
        run_cycles(FR);
        chk("steps_collapse", steps - base, 1);

        // Second edge lands on the release cycle: two steps, a frame apart.
        wait_pos(0, 2);
        base = steps;
        tick_in = 1'b1;
        wait_pos(0, 4);
        tick_in = 1'b0;
        wait_pos(45, 23);
        tick_in = 1'b1;
        wait_pos(0, 26);
        tick_in = 1'b0;
        chk("steps_collide_first", steps - base, 1);
        wait_pos(5, 24);
        chk("steps_collide", steps - base, 2);
        run_cycles(FR);
        chk("steps_collide_after", steps - base, 2);

        // Mid-frame reset with a step armed.
        wait_pos(0, 2);
        tick_in = 1'b1;
        wait_pos(0, 4);
        tick_in = 1'b0;
        wait_pos(30, 10);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_x", pixel_x, 0);
        chk("mid_rst_y", pixel_y, 0);
        chk("mid_rst_video", video_on, 0);
        chk("mid_rst_hsync", hsync, 1);
        chk("mid_rst_vsync", vsync, 1);
        chk("mid_rst_pulses",
            {line_start, frame_start, vblank_start, game_step}, 0);
        run_cycles(3);
        #2 reset = 1'b0;
        base = steps;
        @(negedge clk);
        chk("post_rst_fs", frame_start, 1);
        chk("post_rst_xy", {pixel_x, pixel_y}, 0);
        run_cycles(2 * FR);
        chk("steps_after_reset", steps - base, 0);

        // Random tick activity checked cycle by cycle against the model.
        for (int i = 0; i < 10 * FR; i++) begin
            @(negedge clk);
            if ($urandom_range(299) == 0) tick_in = ~tick_in;
        end
        run_cycles(2 * FR);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
